// File: rtl/spike_rate_decoder_if.sv
// Spike-rate decoder signal bundle: neuron-side inputs and readout outputs.
// The master drives en/spike_in/window_len; the decoder (slave) drives the readouts.
interface spike_rate_decoder_if #(
    parameter int WINDOW_W = 16,
    parameter int COUNT_W  = 8,
    parameter int ISI_W    = 16
);
    logic                en;
    logic                spike_in;
    logic [WINDOW_W-1:0] window_len;
    logic [COUNT_W-1:0]  rate_out;
    logic                rate_valid;
    logic                rate_sat;
    logic [ISI_W-1:0]    isi_out;
    logic                isi_valid;

    modport master (
        output en, spike_in, window_len,
        input  rate_out, rate_valid, rate_sat, isi_out, isi_valid
    );

    modport slave (
        input  en, spike_in, window_len,
        output rate_out, rate_valid, rate_sat, isi_out, isi_valid
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Converts a neuron spike train back into numbers: spike count per back-to-back
// window (rate code) and cycles between consecutive spike edges (ISI code).
module spike_rate_decoder #(
    parameter int WINDOW_W = 16,
    parameter int COUNT_W  = 8,
    parameter int ISI_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    spike_rate_decoder_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [ISI_W-1:0]   ISI_MAX   = {ISI_W{1'b1}};

    state_e              state_q,      state_d;
    logic [WINDOW_W-1:0] timer_q,      timer_d;
    logic [COUNT_W-1:0]  count_q,      count_d;
    logic                sat_q,        sat_d;
    logic                spike_prev_q, spike_prev_d;
    logic                first_seen_q, first_seen_d;
    logic [ISI_W-1:0]    isi_cnt_q,    isi_cnt_d;
    logic [COUNT_W-1:0]  rate_out_q,   rate_out_d;
    logic                rate_sat_q,   rate_sat_d;
    logic                rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]    isi_out_q,    isi_out_d;
    logic                isi_valid_q,  isi_valid_d;

    logic                spike_edge;
    logic [COUNT_W-1:0]  count_upd;
    logic                sat_upd;

    assign spike_edge = bus.spike_in & ~spike_prev_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        timer_d      = timer_q;
        count_d      = count_q;
        sat_d        = sat_q;
        spike_prev_d = bus.spike_in;
        first_seen_d = first_seen_q;
        isi_cnt_d    = isi_cnt_q;
        rate_out_d   = rate_out_q;
        rate_sat_d   = rate_sat_q;
        rate_valid_d = 1'b0;
        isi_out_d    = isi_out_q;
        isi_valid_d  = 1'b0;

        // Count as it would stand after this cycle, including an edge seen now.
        count_upd = count_q;
        sat_upd   = sat_q;
        if (spike_edge) begin
            if (count_q == COUNT_MAX) sat_upd = 1'b1;
            else                      count_upd = count_q + COUNT_W'(1);
        end

        if (!bus.en) begin
            // Disable wins even on a window's last cycle: the window is dropped unreported.
            state_d      = ST_IDLE;
            timer_d      = '0;
            count_d      = '0;
            sat_d        = 1'b0;
            first_seen_d = 1'b0;
            isi_cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.window_len != '0) begin
                        state_d = ST_COUNT;
                        timer_d = bus.window_len;
                        count_d = '0;
                        sat_d   = 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (timer_q == WINDOW_W'(1)) begin
                        rate_out_d   = count_upd;
                        rate_sat_d   = sat_upd;
                        rate_valid_d = 1'b1;
                        count_d      = '0;
                        sat_d        = 1'b0;
                        if (bus.window_len != '0) begin
                            timer_d = bus.window_len;
                        end else begin
                            state_d = ST_IDLE;
                            timer_d = '0;
                        end
                    end else begin
                        timer_d = timer_q - WINDOW_W'(1);
                        count_d = count_upd;
                        sat_d   = sat_upd;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // isi_cnt_q equals cycles elapsed since the previous edge.
            if (spike_edge) begin
                if (first_seen_q) begin
                    isi_out_d   = isi_cnt_q;
                    isi_valid_d = 1'b1;
                end
                first_seen_d = 1'b1;
                isi_cnt_d    = ISI_W'(1);
            end else if (first_seen_q && isi_cnt_q != ISI_MAX) begin
                isi_cnt_d = isi_cnt_q + ISI_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only here, so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            sat_q        <= 1'b0;
            spike_prev_q <= 1'b0;
            first_seen_q <= 1'b0;
            isi_cnt_q    <= '0;
            rate_out_q   <= '0;
            rate_sat_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
            spike_prev_q <= spike_prev_d;
            first_seen_q <= first_seen_d;
            isi_cnt_q    <= isi_cnt_d;
            rate_out_q   <= rate_out_d;
            rate_sat_q   <= rate_sat_d;
            rate_valid_q <= rate_valid_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign bus.rate_out   = rate_out_q;
    assign bus.rate_sat   = rate_sat_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.isi_out    = isi_out_q;
    assign bus.isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a default instance plus a 4-bit-ISI
// instance sharing the same inputs for the ISI saturation case.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        spike_in = 1'b0;
    logic [15:0] window_len = '0;

    int errors = 0;
    int checks = 0;

    // Per-run observations collected by drive_cycles
    int          v_cnt;
    int          v_cyc;
    logic [7:0]  v_rate;
    logic        v_sat;
    int          i_n;
    int          i_cyc [4];
    logic [15:0] i_val [4];
    int          i4_n;
    logic [3:0]  i4_last;

    spike_rate_decoder_if #(.WINDOW_W(16), .COUNT_W(8), .ISI_W(16)) bus ();
    spike_rate_decoder_if #(.WINDOW_W(16), .COUNT_W(8), .ISI_W(4))  bus4 ();

    assign bus.en          = en;
    assign bus.spike_in    = spike_in;
    assign bus.window_len  = window_len;
    assign bus4.en         = en;
    assign bus4.spike_in   = spike_in;
    assign bus4.window_len = window_len;

    spike_rate_decoder #(.WINDOW_W(16), .COUNT_W(8), .ISI_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    spike_rate_decoder #(.WINDOW_W(16), .COUNT_W(8), .ISI_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c (1-based) drives spike_in from pat[c-1], or high on odd cycles if toggle.
    task automatic drive_cycles(input int n, input logic [127:0] pat, input bit toggle);
        v_cnt = 0; v_cyc = 0; v_rate = '0; v_sat = 1'b0;
        i_n = 0; i4_n = 0; i4_last = '0;
        for (int c = 1; c <= n; c++) begin
            if (toggle) spike_in = (c % 2 == 1);
            else        spike_in = (c <= 128) ? pat[c-1] : 1'b0;
            tick();
            if (bus.rate_valid) begin
                v_cnt++; v_cyc = c; v_rate = bus.rate_out; v_sat = bus.rate_sat;
            end
            if (bus.isi_valid) begin
                if (i_n < 4) begin i_cyc[i_n] = c; i_val[i_n] = bus.isi_out; end
                i_n++;
            end
            if (bus4.isi_valid) begin
                i4_n++; i4_last = bus4.isi_out;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; spike_in = 1'b0; window_len = '0;
        tick(); tick();
        checks++;
        if ({bus.rate_out, bus.rate_valid, bus.rate_sat, bus.isi_out, bus.isi_valid} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rate=%0d rv=%0b rs=%0b isi=%0d iv=%0b expected all 0",
                     bus.rate_out, bus.rate_valid, bus.rate_sat, bus.isi_out, bus.isi_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_count();
        en = 1'b1; window_len = 16'd10;
        tick();
        drive_cycles(10, 128'h92, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 10) begin
            errors++; $display("FAIL count_timing: got %0d pulses last at %0d expected 1 at 10", v_cnt, v_cyc);
        end
        checks++;
        if (v_rate !== 8'd3 || v_sat !== 1'b0) begin
            errors++; $display("FAIL count_value: got rate=%0d sat=%0b expected 3/0", v_rate, v_sat);
        end
        drive_cycles(10, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 10 || v_rate !== 8'd0) begin
            errors++; $display("FAIL back_to_back_empty: got %0d pulses at %0d rate=%0d expected 1 at 10 rate=0",
                               v_cnt, v_cyc, v_rate);
        end
    endtask

    task automatic test_held_spike();
        drive_cycles(10, 128'h3C, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_rate !== 8'd1) begin
            errors++; $display("FAIL held_spike: got %0d pulses rate=%0d expected 1 pulse rate=1", v_cnt, v_rate);
        end
        drive_cycles(10, 128'h200, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 10 || v_rate !== 8'd1) begin
            errors++; $display("FAIL last_cycle_edge: got %0d pulses at %0d rate=%0d expected 1 at 10 rate=1",
                               v_cnt, v_cyc, v_rate);
        end
        drive_cycles(10, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_rate !== 8'd0) begin
            errors++; $display("FAIL edge_not_carried: got %0d pulses rate=%0d expected 1 pulse rate=0", v_cnt, v_rate);
        end
    endtask

    task automatic test_saturation();
        en = 1'b0; tick();
        en = 1'b1; window_len = 16'd1000;
        tick();
        drive_cycles(1000, 128'h0, 1'b1);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 1000 || v_rate !== 8'd255 || v_sat !== 1'b1) begin
            errors++; $display("FAIL saturate: got %0d pulses at %0d rate=%0d sat=%0b expected 1 at 1000 rate=255 sat=1",
                               v_cnt, v_cyc, v_rate, v_sat);
        end
        drive_cycles(1000, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_rate !== 8'd0 || v_sat !== 1'b0) begin
            errors++; $display("FAIL sat_clears: got %0d pulses rate=%0d sat=%0b expected 1 pulse rate=0 sat=0",
                               v_cnt, v_rate, v_sat);
        end
    endtask

    task automatic test_isi();
        logic [127:0] pat;
        en = 1'b0; tick();
        en = 1'b1; window_len = 16'd0;
        pat = (128'd1 << 19) | (128'd1 << 26) | (128'd1 << 99);
        drive_cycles(110, pat, 1'b0);
        checks++;
        if (i_n !== 2) begin
            errors++; $display("FAIL isi_pulses: got %0d expected 2", i_n);
        end else begin
            checks++;
            if (i_cyc[0] !== 27 || i_val[0] !== 16'd7) begin
                errors++; $display("FAIL isi_first: got %0d at %0d expected 7 at 27", i_val[0], i_cyc[0]);
            end
            checks++;
            if (i_cyc[1] !== 100 || i_val[1] !== 16'd73) begin
                errors++; $display("FAIL isi_second: got %0d at %0d expected 73 at 100", i_val[1], i_cyc[1]);
            end
        end
        checks++;
        if (v_cnt !== 0) begin
            errors++; $display("FAIL zero_len_idle: got %0d rate pulses expected 0", v_cnt);
        end

        en = 1'b0; tick();
        en = 1'b1;
        pat = (128'd1 << 9) | (128'd1 << 49);
        drive_cycles(60, pat, 1'b0);
        checks++;
        if (i_n !== 1 || i_val[0] !== 16'd40) begin
            errors++; $display("FAIL isi_40: got %0d pulses value=%0d expected 1 pulse value=40", i_n, i_val[0]);
        end
        checks++;
        if (i4_n !== 1 || i4_last !== 4'd15) begin
            errors++; $display("FAIL isi_sat4: got %0d pulses value=%0d expected 1 pulse value=15", i4_n, i4_last);
        end
    endtask

    task automatic test_disable();
        en = 1'b0; spike_in = 1'b0; tick();
        en = 1'b1; window_len = 16'd10;
        tick();
        drive_cycles(10, 128'h12, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_rate !== 8'd2) begin
            errors++; $display("FAIL pre_disable_window: got %0d pulses rate=%0d expected 1 pulse rate=2", v_cnt, v_rate);
        end
        drive_cycles(5, 128'h5, 1'b0);
        en = 1'b0;
        drive_cycles(15, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 0 || bus.rate_out !== 8'd2) begin
            errors++; $display("FAIL disable_discard: got %0d pulses rate_out=%0d expected 0 pulses rate_out=2",
                               v_cnt, bus.rate_out);
        end
        checks++;
        if (bus.isi_out !== 16'd2) begin
            errors++; $display("FAIL disable_isi_hold: got %0d expected 2", bus.isi_out);
        end
        en = 1'b1;
        tick();
        drive_cycles(10, 128'h8, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 10 || v_rate !== 8'd1) begin
            errors++; $display("FAIL reenable_window: got %0d pulses at %0d rate=%0d expected 1 at 10 rate=1",
                               v_cnt, v_cyc, v_rate);
        end
        checks++;
        if (i_n !== 0) begin
            errors++; $display("FAIL reenable_isi_first: got %0d isi pulses expected 0", i_n);
        end

        drive_cycles(4, 128'h2, 1'b0);
        rst = 1'b1; spike_in = 1'b1;
        tick();
        checks++;
        if ({bus.rate_out, bus.rate_valid, bus.rate_sat, bus.isi_out, bus.isi_valid} !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid_window: got rate=%0d rv=%0b rs=%0b isi=%0d iv=%0b expected all 0",
                     bus.rate_out, bus.rate_valid, bus.rate_sat, bus.isi_out, bus.isi_valid);
        end
        rst = 1'b0; spike_in = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_window_len();
        en = 1'b1; window_len = 16'd0;
        drive_cycles(50, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 0) begin
            errors++; $display("FAIL zero_len_50: got %0d rate pulses expected 0", v_cnt);
        end
        window_len = 16'd10;
        tick();
        drive_cycles(3, 128'h0, 1'b0);
        window_len = 16'd4;
        drive_cycles(7, 128'h0, 1'b0);
        checks++;
        if (v_cnt !== 1 || v_cyc !== 7) begin
            errors++; $display("FAIL len_change_current: got %0d pulses at %0d expected 1 at 7", v_cnt, v_cyc);
        end
        for (int w = 0; w < 2; w++) begin
            drive_cycles(4, 128'h0, 1'b0);
            checks++;
            if (v_cnt !== 1 || v_cyc !== 4) begin
                errors++; $display("FAIL len_change_next%0d: got %0d pulses at %0d expected 1 at 4", w, v_cnt, v_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_held_spike();
        test_saturation();
        test_isi();
        test_disable();
        test_window_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receive-side companion to the neuron core: it consumes the neuron's spike output and converts it back into numbers. It reports the spike count over a programmable, back-to-back time window (rate code) and the interval between consecutive spikes (ISI code). Its outputs feed the debug/readout pins and closed-loop current controllers.

Parameters:
WINDOW_W, 16, width of window length and window timer
COUNT_W, 8, width of spike count / rate_out
ISI_W, 16, width of inter-spike-interval counter / isi_out

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  decoder enable; low = idle, state cleared
spike_in  input  1  spike from neuron, level signal, may stay high several cycles
window_len  input  WINDOW_W  window length in cycles, sampled at each window start
rate_out  output  COUNT_W  spike count of last completed window
rate_valid  output  1  one-cycle pulse when rate_out updates
rate_sat  output  1  last completed window saturated its count
isi_out  output  ISI_W  cycles between last two spike edges
isi_valid  output  1  one-cycle pulse when isi_out updates

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM=IDLE, timer/count/ISI counter 0, spike_prev 0, first_seen 0. rst has priority over everything.
- Edge detect: spike_prev registered every cycle, including IDLE. edge = spike_in & ~spike_prev. A spike held high N cycles counts as one spike. Minimum edge spacing is 2 cycles.
- FSM states: IDLE, COUNT.
- IDLE -> COUNT when en=1 and window_len!=0.
  - On entry, timer <= window_len and count <= 0.
  - An edge in the entry cycle is not counted.
  - window_len=0 keeps the FSM in IDLE.
- COUNT, each cycle:
  - timer decrements.
  - On an edge, count <= count+1, saturating at 2^COUNT_W-1. An internal sat flag is set if an increment is attempted at max.
- Window end (COUNT and timer==1):
  - Next cycle: rate_out <= final count, including an edge in this last cycle; rate_sat <= sat flag; rate_valid=1 for exactly one cycle.
  - count and sat flag clear.
  - If en=1 and window_len!=0, timer reloads from current window_len with no gap cycle. Otherwise the FSM goes to IDLE.
  - Window length is exactly window_len cycles. A window_len change mid-window takes effect only at the next reload.
- en=0 in any state:
  - Next cycle FSM=IDLE; count, timer, sat flag and ISI state clear.
  - The partial window is discarded: no rate_valid.
  - rate_out, rate_sat and isi_out hold their last values.
- ISI:
  - Active only while en=1.
  - First edge after en rises or after reset sets first_seen; no isi_valid is produced.
  - Each subsequent edge: next cycle isi_out <= t_edge - t_prev_edge (cycles) and isi_valid=1 for one cycle. The value saturates at 2^ISI_W-1 if the interval exceeds it.
  - ISI tracking is independent of window boundaries and continues across them.
- rate_valid and isi_valid may assert in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Count: rst, then en=1, window_len=10; one-cycle spikes at window cycles 2,5,8 -> rate_valid one cycle after cycle 10, rate_out=3, rate_sat=0. Next window with no spikes -> rate_out=0 exactly 10 cycles later.
2. Held spike: spike_in high 4 cycles inside a window_len=10 window -> rate_out=1. Spike edge on the last window cycle -> counted in that window, not the next.
3. Saturation: COUNT_W=8, window_len=1000, spike toggling every cycle (500 edges) -> rate_out=255, rate_sat=1. Following quiet window -> rate_sat=0.
4. ISI: edges at cycles 20, 27, 100 after en -> no isi_valid at 20; isi_out=7 at 27+1; isi_out=73 at 100+1. With ISI_W=4 and a 40-cycle gap -> isi_out=15.
5. Disable/reset mid-window:
   - en low at window cycle 6 -> no rate_valid, rate_out holds. Re-enable -> full new window_len window.
   - rst mid-window -> all outputs 0 next cycle.
6. Zero/changed length: window_len=0 with en=1 -> no rate_valid for 50 cycles. Change window_len 10->4 mid-window -> current window ends at 10, next at 4.
